// File: rtl/alu_result_stage.sv
// Registered result/flag stage behind the ALU: computes N/Z/C/V, buffers two entries toward writeback.
// Optional saturating illegal-opcode retire counter is built when ALU_STAGE_ILLEGAL_CNT_EN is defined.
module alu_result_stage #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_optcode,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic [WIDTH-1:0]  in_result,
    input  logic [ADDR_W-1:0] in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_result,
    output logic [ADDR_W-1:0] out_dest,
    output logic              out_wen,
    output logic [3:0]        out_flags,
    output logic [3:0]        flags_q,
    output logic [7:0]        illegal_count
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_CMP = 4'd9;
    localparam logic [1:0] FULL_CNT = 2'(DEPTH);

    logic [WIDTH:0]  sum_ext;
    logic            cap_illegal;
    logic            cap_wen;
    logic [3:0]      cap_flags;
    logic            a_msb, b_msb, r_msb;

    assign sum_ext = {1'b0, in_a} + {1'b0, in_b};
    assign a_msb   = in_a[WIDTH-1];
    assign b_msb   = in_b[WIDTH-1];
    assign r_msb   = in_result[WIDTH-1];

    // N/Z come from the ALU result; C/V only meaningful for add and subtract forms
    always_comb begin
        cap_illegal = (in_optcode > OP_CMP);
        cap_wen     = (in_optcode < OP_CMP);
        cap_flags   = 4'b0000;
        if (!cap_illegal) begin
            cap_flags[3] = r_msb;
            cap_flags[2] = (in_result == '0);
            if (in_optcode == OP_ADD) begin
                cap_flags[1] = sum_ext[WIDTH];
                cap_flags[0] = (a_msb == b_msb) && (r_msb != a_msb);
            end else if (in_optcode == OP_SUB || in_optcode == OP_CMP) begin
                cap_flags[1] = (in_a >= in_b);
                cap_flags[0] = (a_msb != b_msb) && (r_msb != a_msb);
            end
        end
    end

    logic [WIDTH-1:0]  buf_result  [2];
    logic [ADDR_W-1:0] buf_dest    [2];
    logic              buf_wen     [2];
    logic [3:0]        buf_flags   [2];
    logic              buf_illegal [2];
    logic              rd_ptr, wr_ptr;
    logic [1:0]        count, count_next;
    logic              in_ready_q;
    logic              accept, retire;

    assign out_valid  = (count != 2'd0);
    assign in_ready   = in_ready_q;
    assign accept     = in_valid && in_ready_q;
    assign retire     = out_valid && out_ready;
    assign out_result = buf_result[rd_ptr];
    assign out_dest   = buf_dest[rd_ptr];
    assign out_wen    = buf_wen[rd_ptr];
    assign out_flags  = buf_flags[rd_ptr];

    always_comb begin
        count_next = count;
        if (accept && !retire)
            count_next = count + 2'd1;
        else if (retire && !accept)
            count_next = count - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
            in_ready_q <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                buf_result[i]  <= '0;
                buf_dest[i]    <= '0;
                buf_wen[i]     <= 1'b0;
                buf_flags[i]   <= 4'b0000;
                buf_illegal[i] <= 1'b0;
            end
        end else begin
            count      <= count_next;
            // registered so in_ready never depends combinationally on out_ready
            in_ready_q <= (count_next != FULL_CNT);
            if (retire)
                rd_ptr <= ~rd_ptr;
            if (accept) begin
                wr_ptr              <= ~wr_ptr;
                buf_result[wr_ptr]  <= in_result;
                buf_dest[wr_ptr]    <= in_dest;
                buf_wen[wr_ptr]     <= cap_wen;
                buf_flags[wr_ptr]   <= cap_flags;
                buf_illegal[wr_ptr] <= cap_illegal;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            flags_q <= 4'b0000;
        else if (retire && !buf_illegal[rd_ptr])
            flags_q <= buf_flags[rd_ptr];
    end

`ifdef ALU_STAGE_ILLEGAL_CNT_EN
    logic [7:0] illegal_cnt_q;

    always_ff @(posedge clk) begin
        if (reset)
            illegal_cnt_q <= 8'd0;
        else if (retire && buf_illegal[rd_ptr] && illegal_cnt_q != 8'hFF)
            illegal_cnt_q <= illegal_cnt_q + 8'd1;
    end

    assign illegal_count = illegal_cnt_q;
`else
    assign illegal_count = 8'd0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed flag vectors, handshake corner sequences and a randomized scoreboard run.
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_optcode;
    logic [31:0] in_a, in_b, in_result;
    logic [4:0]  in_dest;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_dest;
    logic        out_wen;
    logic [3:0]  out_flags;
    logic [3:0]  flags_q;
    logic [7:0]  illegal_count;

    alu_result_stage #(.WIDTH(32), .ADDR_W(5), .DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_optcode(in_optcode),
        .in_a(in_a), .in_b(in_b), .in_result(in_result), .in_dest(in_dest),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_dest(out_dest), .out_wen(out_wen), .out_flags(out_flags),
        .flags_q(flags_q), .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, r;
        logic        wen;
        logic [3:0]  flags;
    } vec_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] result;
        logic [4:0]  dest;
        logic        wen;
        logic [3:0]  flags;
    } ent_t;

    vec_t vecs[10];
    ent_t model_q[$];
    logic [3:0] m_flags;
    int         m_illegal;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] r, input logic [4:0] d);
        in_valid   = v;
        in_optcode = op;
        in_a       = a;
        in_b       = b;
        in_result  = r;
        in_dest    = d;
    endtask

    function automatic logic [7:0] exp_illegal(input int cnt);
`ifdef ALU_STAGE_ILLEGAL_CNT_EN
        return (cnt > 255) ? 8'd255 : 8'(cnt);
`else
        return 8'd0 + 8'(cnt & 0);
`endif
    endfunction

    // Flags from signed/unsigned arithmetic on wide integers; assumes r is the true ALU result
    function automatic logic [3:0] ref_flags(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] r);
        longint ua, ub, sa, sb, s;
        logic n, z, c, v;
        if (op > 4'd9) return 4'b0000;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        n = (r >= 32'h8000_0000);
        z = (r == 32'd0);
        c = 1'b0;
        v = 1'b0;
        if (op == 4'd0) begin
            c = (ua + ub) > 64'sd4294967295;
            s = sa + sb;
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (op == 4'd1 || op == 4'd9) begin
            c = (ua >= ub);
            s = sa - sb;
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        return {n, z, c, v};
    endfunction

    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            4'd0:       return a + b;
            4'd1, 4'd9: return a - b;
            4'd2:       return a * b;
            4'd3:       return a | b;
            4'd4:       return a & b;
            4'd5:       return a ^ b;
            4'd6:       return a >> sh;
            4'd7:       return a << sh;
            4'd8:       return (sh == 0) ? a : ((a >> sh) | (a << (32 - sh)));
            default:    return $urandom;
        endcase
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0]  exp_fq;
        int          exp_ill;
        logic [3:0]  op;
        logic [31:0] a, b, r;
        logic [4:0]  d;
        logic        v, rdy, acc, ret;
        ent_t        e;

        vecs[0] = '{4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 4'b0110};
        vecs[1] = '{4'd1,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 4'b0011};
        vecs[2] = '{4'd9,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 4'b0011};
        vecs[3] = '{4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 4'b1001};
        vecs[4] = '{4'd1,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b1, 4'b1000};
        vecs[5] = '{4'd1,  32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b1, 4'b0110};
        vecs[6] = '{4'd4,  32'h0000_00F0, 32'h0000_000F, 32'h0000_0000, 1'b1, 4'b0100};
        vecs[7] = '{4'd3,  32'h8000_0000, 32'h0000_0001, 32'h8000_0001, 1'b1, 4'b1000};
        vecs[8] = '{4'd2,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 4'b0000};
        vecs[9] = '{4'd15, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, 4'b0000};

        drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        out_ready = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;

        check("reset_out_valid", out_valid, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_result", out_result, 32'd0);
        check("reset_out_dest", out_dest, 5'd0);
        check("reset_out_wen", out_wen, 1'b0);
        check("reset_out_flags", out_flags, 4'd0);
        check("reset_flags_q", flags_q, 4'd0);
        check("reset_illegal_count", illegal_count, 8'd0);

        // Directed flag vectors, one entry at a time with writeback always ready
        exp_fq  = 4'd0;
        exp_ill = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, 5'(i + 3));
            step();
            drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0);
            check($sformatf("vec%0d_out_valid", i), out_valid, 1'b1);
            check($sformatf("vec%0d_out_result", i), out_result, vecs[i].r);
            check($sformatf("vec%0d_out_dest", i), out_dest, 5'(i + 3));
            check($sformatf("vec%0d_out_wen", i), out_wen, vecs[i].wen);
            check($sformatf("vec%0d_out_flags", i), out_flags, vecs[i].flags);
            check($sformatf("vec%0d_flags_q_before", i), flags_q, exp_fq);
            step();
            if (vecs[i].op <= 4'd9) exp_fq = vecs[i].flags;
            else exp_ill++;
            check($sformatf("vec%0d_flags_q_after", i), flags_q, exp_fq);
            check($sformatf("vec%0d_drained", i), out_valid, 1'b0);
            check($sformatf("vec%0d_illegal_count", i), illegal_count, exp_illegal(exp_ill));
        end

        // Back-pressure: three back-to-back pushes with writeback stalled
        do_reset();
        out_ready = 1'b0;
        drive(1'b1, 4'd3, 32'h1, 32'h2, 32'h0000_0003, 5'd1);
        step();
        check("bp_ready_after_1", in_ready, 1'b1);
        check("bp_valid_after_1", out_valid, 1'b1);
        drive(1'b1, 4'd5, 32'h1, 32'h2, 32'h0000_0030, 5'd2);
        step();
        check("bp_ready_after_2", in_ready, 1'b0);
        drive(1'b1, 4'd4, 32'h1, 32'h2, 32'h0000_0300, 5'd3);
        step();
        check("bp_ready_held", in_ready, 1'b0);
        check("bp_head_stable_a", out_result, 32'h0000_0003);
        step();
        check("bp_head_stable_b", out_result, 32'h0000_0003);
        check("bp_head_dest", out_dest, 5'd1);
        out_ready = 1'b1;
        step();
        check("bp_retire1_head", out_result, 32'h0000_0030);
        check("bp_retire1_ready", in_ready, 1'b1);
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        check("bp_retire2_head", out_result, 32'h0000_0300);
        check("bp_retire2_valid", out_valid, 1'b1);
        check("bp_retire2_dest", out_dest, 5'd3);
        step();
        check("bp_empty", out_valid, 1'b0);
        check("bp_flags_q", flags_q, 4'b0000);

        // Illegal opcode between a SUB and an AND
        do_reset();
        out_ready = 1'b1;
        drive(1'b1, 4'd1, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 5'd4);
        step();
        drive(1'b1, 4'd12, 32'h0, 32'h0, 32'h0, 5'd5);
        step();
        check("ill_flags_q_sub", flags_q, 4'b0011);
        check("ill_head_wen", out_wen, 1'b0);
        check("ill_head_flags", out_flags, 4'b0000);
        drive(1'b1, 4'd4, 32'h0F, 32'hF0, 32'h0, 5'd6);
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        check("ill_flags_q_kept", flags_q, 4'b0011);
        check("ill_count", illegal_count, exp_illegal(1));
        step();
        check("ill_and_flags_q", flags_q, 4'b0100);

        // Reset with two entries held
        out_ready = 1'b0;
        drive(1'b1, 4'd0, 32'h5, 32'h6, 32'hB, 5'd7);
        step();
        drive(1'b1, 4'd14, 32'h5, 32'h6, 32'hB, 5'd8);
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        check("rst_full", in_ready, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_flags_q", flags_q, 4'd0);
        check("rst_illegal_count", illegal_count, 8'd0);
        step();
        check("rst_stays_empty", out_valid, 1'b0);

        // Randomized run against the queue model
        model_q.delete();
        m_flags   = 4'd0;
        m_illegal = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            check("rnd_out_valid", out_valid, model_q.size() != 0);
            check("rnd_in_ready", in_ready, model_q.size() < 2);
            check("rnd_flags_q", flags_q, m_flags);
            check("rnd_illegal_count", illegal_count, exp_illegal(m_illegal));
            if (model_q.size() != 0) begin
                check("rnd_out_result", out_result, model_q[0].result);
                check("rnd_out_dest", out_dest, model_q[0].dest);
                check("rnd_out_wen", out_wen, model_q[0].wen);
                check("rnd_out_flags", out_flags, model_q[0].flags);
            end
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            op  = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       a = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                1:       a = 32'h8000_0000 + 32'($urandom_range(0, 3)) - 32'd2;
                default: a = $urandom;
            endcase
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 4) == 0) b = 32'($urandom_range(0, 2));
            r = ref_result(op, a, b);
            d = 5'($urandom_range(0, 31));
            drive(v, op, a, b, r, d);
            out_ready = rdy;
            acc = v && (model_q.size() < 2);
            ret = (model_q.size() != 0) && rdy;
            step();
            if (ret) begin
                e = model_q.pop_front();
                if (e.op <= 4'd9) m_flags = e.flags;
                else m_illegal++;
            end
            if (acc) begin
                e.op     = op;
                e.result = r;
                e.dest   = d;
                e.wen    = (op <= 4'd8);
                e.flags  = ref_flags(op, a, b, r);
                model_q.push_back(e);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
